// File: rtl/three_level_sequencer.sv
// Three-level full-bridge gate sequencer.
// The bridge steps through +1, 0, -1, 0 with programmable on, zero and
// dead-time durations. Both switches of a commutating leg are held off for
// the dead-time. Fault drops every gate at once; a stop request always
// releases the bridge from a zero state.
module three_level_sequencer #(
  parameter int CNT_W  = 16,
  parameter int DT_MIN = 2
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_EN,
  input  logic             i_FAULT,
  input  logic [CNT_W-1:0] i_T_ON,
  input  logic [CNT_W-1:0] i_T_ZERO,
  input  logic [CNT_W-1:0] i_DT,
  output logic [3:0]       o_MOSFET,
  output logic [31:0]      o_sigma,
  output logic             o_busy,
  output logic             o_period,
  output logic             o_fault
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_POS   = 4'd1,
    S_DT_PZ = 4'd2,
    S_ZERO1 = 4'd3,
    S_DT_ZN = 4'd4,
    S_NEG   = 4'd5,
    S_DT_NP = 4'd6,
    S_ZERO2 = 4'd7,
    S_DT_ZP = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DT_FLOOR = CNT_W'(DT_MIN);
  localparam logic signed [31:0] SIG_POS = 32'sd1;
  localparam logic signed [31:0] SIG_ZER = 32'sd0;
  localparam logic signed [31:0] SIG_NEG = -32'sd1;

  // Gate patterns: bit0/bit2 form leg A, bit1/bit3 form leg B.
  localparam logic [3:0] G_OFF  = 4'b0000;
  localparam logic [3:0] G_POS  = 4'b1001;
  localparam logic [3:0] G_BOFF = 4'b0001;
  localparam logic [3:0] G_ZERO = 4'b0011;
  localparam logic [3:0] G_AOFF = 4'b0010;
  localparam logic [3:0] G_NEG  = 4'b0110;

  // A timed state lasts max(v,1) clocks: the counter starts at that minus one.
  function automatic logic [CNT_W-1:0] load_cnt(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : (v - CNT_ONE);
  endfunction

  // Dead-time is never shorter than the DT_MIN floor.
  function automatic logic [CNT_W-1:0] clamp_dt(input logic [CNT_W-1:0] v);
    return (v < DT_FLOOR) ? DT_FLOOR : v;
  endfunction

  function automatic logic [3:0] gates_of(input state_t s);
    logic [3:0] g;
    case (s)
      S_POS:   g = G_POS;
      S_DT_PZ: g = G_BOFF;
      S_ZERO1: g = G_ZERO;
      S_DT_ZN: g = G_AOFF;
      S_NEG:   g = G_NEG;
      S_DT_NP: g = G_AOFF;
      S_ZERO2: g = G_ZERO;
      S_DT_ZP: g = G_BOFF;
      default: g = G_OFF;
    endcase
    return g;
  endfunction

  // Dead-time states keep reporting the level that preceded them.
  function automatic logic signed [31:0] sigma_of(input state_t s);
    logic signed [31:0] v;
    case (s)
      S_POS, S_DT_PZ: v = SIG_POS;
      S_NEG, S_DT_NP: v = SIG_NEG;
      default:        v = SIG_ZER;
    endcase
    return v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ton_q, ton_d;
  logic [CNT_W-1:0]   tz_q, tz_d;
  logic [CNT_W-1:0]   dt_q, dt_d;
  logic               pos_entry_q, pos_entry_d;
  logic [3:0]         mosfet_q, mosfet_d;
  logic signed [31:0] sigma_q, sigma_d;
  logic               busy_q, busy_d;
  logic               period_q, period_d;
  logic               fault_q, fault_d;

  logic               expired;
  logic               go_pos;
  logic               dt_skip;
  logic [CNT_W-1:0]   dt_load;
  logic [CNT_W-1:0]   dec_cnt;

  // Sequence control: next state, down-counter and once-per-period timing latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ton_d       = ton_q;
    tz_d        = tz_q;
    dt_d        = dt_q;
    pos_entry_d = 1'b0;
    go_pos      = 1'b0;
    expired     = (cnt_q == '0);
    dec_cnt     = cnt_q - CNT_ONE;
    dt_skip     = (clamp_dt(dt_q) == '0);
    dt_load     = load_cnt(clamp_dt(dt_q));

    if (i_FAULT) begin
      state_d = S_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: go_pos = i_EN;

        S_POS: begin
          if (!expired) begin
            cnt_d = dec_cnt;
          end else if (dt_skip) begin
            state_d = S_ZERO1;
            cnt_d   = load_cnt(tz_q);
          end else begin
            state_d = S_DT_PZ;
            cnt_d   = dt_load;
          end
        end

        S_DT_PZ: begin
          if (!expired) begin
            cnt_d = dec_cnt;
          end else begin
            state_d = S_ZERO1;
            cnt_d   = load_cnt(tz_q);
          end
        end

        S_ZERO1: begin
          if (!expired) begin
            cnt_d = dec_cnt;
          end else if (!i_EN) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (dt_skip) begin
            state_d = S_NEG;
            cnt_d   = load_cnt(ton_q);
          end else begin
            state_d = S_DT_ZN;
            cnt_d   = dt_load;
          end
        end

        S_DT_ZN: begin
          if (!expired) begin
            cnt_d = dec_cnt;
          end else begin
            state_d = S_NEG;
            cnt_d   = load_cnt(ton_q);
          end
        end

        S_NEG: begin
          if (!expired) begin
            cnt_d = dec_cnt;
          end else if (dt_skip) begin
            state_d = S_ZERO2;
            cnt_d   = load_cnt(tz_q);
          end else begin
            state_d = S_DT_NP;
            cnt_d   = dt_load;
          end
        end

        S_DT_NP: begin
          if (!expired) begin
            cnt_d = dec_cnt;
          end else begin
            state_d = S_ZERO2;
            cnt_d   = load_cnt(tz_q);
          end
        end

        S_ZERO2: begin
          if (!expired) begin
            cnt_d = dec_cnt;
          end else if (!i_EN) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (dt_skip) begin
            go_pos = 1'b1;
          end else begin
            state_d = S_DT_ZP;
            cnt_d   = dt_load;
          end
        end

        // The next positive half is already committed once DT_ZP is entered.
        S_DT_ZP: begin
          if (!expired) begin
            cnt_d = dec_cnt;
          end else begin
            go_pos = 1'b1;
          end
        end

        S_FAULT: begin
          if (!i_EN) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // New timings are captured only as a period begins.
    if (go_pos) begin
      state_d     = S_POS;
      cnt_d       = load_cnt(i_T_ON);
      ton_d       = i_T_ON;
      tz_d        = i_T_ZERO;
      dt_d        = i_DT;
      pos_entry_d = 1'b1;
    end
  end

  // Output decode one clock behind the state; a fault blanks the gates at once.
  always_comb begin
    mosfet_d = gates_of(state_q);
    sigma_d  = sigma_of(state_q);
    busy_d   = (state_q != S_IDLE) && (state_q != S_FAULT);
    period_d = pos_entry_q;
    fault_d  = fault_q;
    if ((state_q == S_FAULT) && (state_d == S_IDLE)) begin
      fault_d = 1'b0;
    end
    if (i_FAULT) begin
      mosfet_d = G_OFF;
      sigma_d  = SIG_ZER;
      period_d = 1'b0;
      fault_d  = 1'b1;
    end
  end

  // State, counter, latched timings and output registers.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ton_q       <= '0;
      tz_q        <= '0;
      dt_q        <= '0;
      pos_entry_q <= 1'b0;
      mosfet_q    <= G_OFF;
      sigma_q     <= SIG_ZER;
      busy_q      <= 1'b0;
      period_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ton_q       <= ton_d;
      tz_q        <= tz_d;
      dt_q        <= dt_d;
      pos_entry_q <= pos_entry_d;
      mosfet_q    <= mosfet_d;
      sigma_q     <= sigma_d;
      busy_q      <= busy_d;
      period_q    <= period_d;
      fault_q     <= fault_d;
    end
  end

  assign o_MOSFET = mosfet_q;
  assign o_sigma  = sigma_q;
  assign o_busy   = busy_q;
  assign o_period = period_q;
  assign o_fault  = fault_q;

endmodule

// File: tb/tb_three_level_sequencer.sv
// Bench for three_level_sequencer: directed vector table, multi-cycle
// corner sequences and randomized run against a phase-table reference model.
module tb_three_level_sequencer;

  localparam int CNT_W    = 16;
  localparam int DT_MIN_M = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             flt;
  logic [CNT_W-1:0] ton;
  logic [CNT_W-1:0] tz;
  logic [CNT_W-1:0] dt;
  logic [3:0]       o_MOSFET;
  logic [31:0]      o_sigma;
  logic             o_busy;
  logic             o_period;
  logic             o_fault;

  always #5 clk = ~clk;

  three_level_sequencer #(.CNT_W(CNT_W), .DT_MIN(DT_MIN_M)) dut (
    .i_CLK    (clk),
    .i_RST    (rst_n),
    .i_EN     (en),
    .i_FAULT  (flt),
    .i_T_ON   (ton),
    .i_T_ZERO (tz),
    .i_DT     (dt),
    .o_MOSFET (o_MOSFET),
    .o_sigma  (o_sigma),
    .o_busy   (o_busy),
    .o_period (o_period),
    .o_fault  (o_fault)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a period is eight phases, each with a gate pattern,
  // a level and a duration; outputs appear one clock after the phase.
  localparam logic [3:0] PH_MOS [8] = '{4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                        4'b0110, 4'b0010, 4'b0011, 4'b0001};
  localparam int         PH_SIG [8] = '{1, 1, 0, 0, -1, -1, 0, 0};

  int         m_mode;   // 0 idle, 1 running, 2 fault
  int         m_ph, m_rem, m_lt, m_lz, m_ld;
  bit         m_perp;
  logic [3:0] e_mos;
  logic [31:0] e_sig;
  bit         e_busy, e_per, e_flt;

  function automatic int dur(input int ph);
    if (ph % 2 == 1) return (m_ld < DT_MIN_M) ? DT_MIN_M : m_ld;
    if (ph == 2 || ph == 6) return (m_lz < 1) ? 1 : m_lz;
    return (m_lt < 1) ? 1 : m_lt;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ph = 0; m_rem = 0; m_lt = 0; m_lz = 0; m_ld = 0; m_perp = 0;
    e_mos = 4'b0000; e_sig = 32'd0; e_busy = 0; e_per = 0; e_flt = 0;
  endtask

  task automatic model_latch();
    m_lt = int'(ton); m_lz = int'(tz); m_ld = int'(dt); m_perp = 1;
  endtask

  task automatic model_step();
    if (m_mode == 1) begin
      e_mos = PH_MOS[m_ph]; e_sig = 32'(PH_SIG[m_ph]); e_busy = 1;
    end else begin
      e_mos = 4'b0000; e_sig = 32'd0; e_busy = 0;
    end
    e_per  = m_perp;
    m_perp = 0;
    if (flt) begin
      e_mos = 4'b0000; e_sig = 32'd0; e_per = 0; e_flt = 1; m_mode = 2;
    end else if (m_mode == 2) begin
      if (!en) begin m_mode = 0; e_flt = 0; end
    end else if (m_mode == 0) begin
      if (en) begin m_mode = 1; m_ph = 0; model_latch(); m_rem = dur(0); end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if ((m_ph == 2 || m_ph == 6) && !en) begin
          m_mode = 0;
        end else begin
          m_ph = (m_ph + 1) % 8;
          if (m_ph % 2 == 1 && dur(m_ph) == 0) m_ph = (m_ph + 1) % 8;
          if (m_ph == 0) model_latch();
          m_rem = dur(m_ph);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("mosfet", {28'd0, o_MOSFET}, {28'd0, e_mos});
    chk("sigma",  o_sigma, e_sig);
    chk("busy",   {31'd0, o_busy},   {31'd0, e_busy});
    chk("period", {31'd0, o_period}, {31'd0, e_per});
    chk("fault",  {31'd0, o_fault},  {31'd0, e_flt});
    chk("shoot",  {31'd0, (o_MOSFET[0] & o_MOSFET[2]) | (o_MOSFET[1] & o_MOSFET[3])}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_out(input logic [3:0] m, input logic [31:0] s, input bit use_s,
                          input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (o_MOSFET === m && (!use_s || o_sigma === s)) found = 1;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_period(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (o_period === 1'b1) found = 1;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (o_busy === 1'b0) found = 1;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  // Length of the run of pattern m that includes the current sample.
  task automatic run_len(input logic [3:0] m, output int n);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (o_MOSFET === m) n++;
      else break;
    end
  endtask

  typedef struct {
    logic        en;
    logic        flt;
    logic [3:0]  mos;
    logic [31:0] sig;
    logic        per;
    int          n;
  } vec_t;

  vec_t vt [10];
  int   n, k, pos_cnt, neg_cnt;

  initial begin
    vt[0] = '{1'b1, 1'b0, 4'b0000, 32'd0,         1'b0, 1};
    vt[1] = '{1'b1, 1'b0, 4'b1001, 32'd1,         1'b1, 10};
    vt[2] = '{1'b1, 1'b0, 4'b0001, 32'd1,         1'b0, 3};
    vt[3] = '{1'b1, 1'b0, 4'b0011, 32'd0,         1'b0, 5};
    vt[4] = '{1'b1, 1'b0, 4'b0010, 32'd0,         1'b0, 3};
    vt[5] = '{1'b1, 1'b0, 4'b0110, 32'hFFFFFFFF,  1'b0, 10};
    vt[6] = '{1'b1, 1'b0, 4'b0010, 32'hFFFFFFFF,  1'b0, 3};
    vt[7] = '{1'b1, 1'b0, 4'b0011, 32'd0,         1'b0, 5};
    vt[8] = '{1'b1, 1'b0, 4'b0001, 32'd0,         1'b0, 3};
    vt[9] = '{1'b1, 1'b0, 4'b1001, 32'd1,         1'b1, 10};

    rst_n = 1'b0; en = 1'b0; flt = 1'b0; ton = 16'd10; tz = 16'd5; dt = 16'd3;
    model_reset();
    #12;
    chk("rst_mosfet", {28'd0, o_MOSFET}, 32'd0);
    chk("rst_sigma",  o_sigma, 32'd0);
    chk("rst_busy",   {31'd0, o_busy}, 32'd0);
    chk("rst_period", {31'd0, o_period}, 32'd0);
    chk("rst_fault",  {31'd0, o_fault}, 32'd0);
    rst_n = 1'b1;

    // Nominal run from the vector table.
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < vt[r].n; c++) begin
        en = vt[r].en; flt = vt[r].flt;
        tick();
        chk("vec_mosfet", {28'd0, o_MOSFET}, {28'd0, vt[r].mos});
        chk("vec_sigma",  o_sigma, vt[r].sig);
        chk("vec_period", {31'd0, o_period}, {31'd0, (c == 0) ? vt[r].per : 1'b0});
      end
    end

    // Period spacing, then a mid-POS change of T_ON.
    wait_period("wait_p1");
    k = 0;
    for (int i = 0; i < 200; i++) begin
      tick(); k++;
      if (o_period === 1'b1) break;
    end
    chk("period_len", k, 32'd42);
    ton = 16'd20;
    run_len(4'b1001, n);
    chk("latch_cur", n, 32'd10);
    wait_period("wait_p2");
    run_len(4'b1001, n);
    chk("latch_next", n, 32'd20);

    // Graceful stop requested in the middle of NEG.
    wait_out(4'b0110, 32'd0, 1'b0, "wait_neg");
    tick(); tick();
    en = 1'b0;
    wait_idle("stop_neg");
    tick();
    chk("stop_mos", {28'd0, o_MOSFET}, 32'd0);

    // Clamping: DT=0 becomes DT_MIN, T_ON=0 becomes one clock.
    ton = 16'd0; tz = 16'd3; dt = 16'd0; en = 1'b1;
    wait_period("wait_p3");
    run_len(4'b1001, n);
    chk("ton_min", n, 32'd1);
    run_len(4'b0001, n);
    chk("dt_min", n, 32'd2);

    // Stop requested in DT_ZP: one whole positive half, then release at ZERO1.
    wait_out(4'b0001, 32'd0, 1'b1, "wait_dtzp");
    ton = 16'd3; en = 1'b0;
    pos_cnt = 0; neg_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (o_MOSFET === 4'b1001) pos_cnt++;
      if (o_MOSFET === 4'b0110) neg_cnt++;
      if (o_busy === 1'b0) break;
    end
    chk("dtzp_pos", pos_cnt, 32'd3);
    chk("dtzp_neg", neg_cnt, 32'd0);
    chk("dtzp_idle", {31'd0, o_busy}, 32'd0);

    // Fault in POS; held off while EN stays high.
    ton = 16'd10; tz = 16'd5; dt = 16'd3; en = 1'b1;
    wait_period("wait_p4");
    tick(); tick();
    flt = 1'b1;
    tick();
    chk("flt_mos", {28'd0, o_MOSFET}, 32'd0);
    chk("flt_flag", {31'd0, o_fault}, 32'd1);
    flt = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flt_hold", {31'd0, o_fault}, 32'd1);
      chk("flt_busy", {31'd0, o_busy}, 32'd0);
    end
    en = 1'b0;
    tick();
    chk("flt_clear", {31'd0, o_fault}, 32'd0);
    tick();

    // Asynchronous reset in ZERO1, between clock edges.
    en = 1'b1;
    wait_out(4'b0011, 32'd0, 1'b1, "wait_zero1");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mos", {28'd0, o_MOSFET}, 32'd0);
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    tick(); tick();
    chk("arst_restart", {28'd0, o_MOSFET}, 32'd9);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      if (!flt && $urandom_range(0, 299) == 0) flt = 1'b1;
      else if (flt && $urandom_range(0, 3) == 0) flt = 1'b0;
      ton = CNT_W'($urandom_range(0, 5));
      tz  = CNT_W'($urandom_range(0, 5));
      dt  = CNT_W'($urandom_range(0, 4));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
